// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MIPS memory-stage load/store unit on an SRAM-like req/addr_ok/data_ok bus
// Optional feature macro: MEM_UNALIGNED_EXC_EN (misaligned accesses raise adel/ades instead of being aligned down)
module mem_access_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic                  flush,
    output logic                  busy,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  adel,
    output logic                  ades,
    output logic                  bus_req,
    output logic                  bus_wr,
    output logic [1:0]            bus_size,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [DATA_W/8-1:0]   bus_wstrb,
    output logic [DATA_W-1:0]     bus_wdata,
    input  logic                  bus_addr_ok,
    input  logic                  bus_data_ok,
    input  logic [DATA_W-1:0]     bus_rdata
);
    localparam int OFF_W  = $clog2(DATA_W / 8);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    state_t            state;
    state_t            next_state;
    logic              discard;
    logic              accept;
    logic              err;
    logic [1:0]        eff_size;
    logic [ADDR_W-1:0] acc_addr;
    logic [OFF_W-1:0]  off;
    logic [OFF_W-1:0]  r_off;
    logic              r_signed;
    logic [7:0]        smask;
    logic [STRB_W-1:0] strb;
    logic [DATA_W-1:0] wdata_steer;
    logic [DATA_W-1:0] rd_shift;
    logic [DATA_W-1:0] rd_mask;
    logic [DATA_W-1:0] load_ext;
    logic [6:0]        nbits;
    logic              sbit;

    function automatic logic [ADDR_W-1:0] low_mask(input logic [1:0] size);
        case (size)
            2'd0:    low_mask = '0;
            2'd1:    low_mask = ADDR_W'(1);
            2'd2:    low_mask = ADDR_W'(3);
            default: low_mask = ADDR_W'(7);
        endcase
    endfunction

    // Without the exception feature, a dword on a 32-bit bus degrades to a word
    // and the address is silently aligned down to the access size.
    always_comb begin
`ifdef MEM_UNALIGNED_EXC_EN
        eff_size = req_size;
        acc_addr = req_addr;
        err      = ((DATA_W == 32) && (req_size == 2'd3)) ||
                   ((req_addr & low_mask(req_size)) != '0);
`else
        eff_size = ((DATA_W == 32) && (req_size == 2'd3)) ? 2'd2 : req_size;
        acc_addr = req_addr & ~low_mask(eff_size);
        err      = 1'b0;
`endif
    end

    assign off = acc_addr[OFF_W-1:0];

    always_comb begin
        case (eff_size)
            2'd0:    smask = 8'h01;
            2'd1:    smask = 8'h03;
            2'd2:    smask = 8'h0F;
            default: smask = 8'hFF;
        endcase
        strb        = STRB_W'(smask) << off;
        wdata_steer = req_wdata << {off, 3'b000};
    end

    // Shift the addressed lanes down, then mask to the access width and sign-fill above it.
    always_comb begin
        rd_shift = bus_rdata >> {r_off, 3'b000};
        nbits    = 7'd8 << bus_size;
        rd_mask  = ~({DATA_W{1'b1}} << nbits);
        case (bus_size)
            2'd0:    sbit = rd_shift[7];
            2'd1:    sbit = rd_shift[15];
            2'd2:    sbit = rd_shift[31];
            default: sbit = rd_shift[DATA_W-1];
        endcase
        load_ext = (rd_shift & rd_mask) | ((r_signed & sbit) ? ~rd_mask : '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            discard <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state == IDLE)
                discard <= 1'b0;
            else if (flush && (state == ADDR || state == DATA))
                discard <= 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                accept = req_valid & ~err;
                busy   = accept;
                if (accept)
                    next_state = ADDR;
            end
            ADDR: begin
                busy = 1'b1;
                if (bus_addr_ok)
                    next_state = DATA;
            end
            DATA: begin
                busy = 1'b1;
                if (bus_data_ok)
                    next_state = (discard || flush) ? IDLE : DONE;
            end
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign adel = (state == IDLE) & req_valid & err & ~req_we;
    assign ades = (state == IDLE) & req_valid & err & req_we;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_req   <= 1'b0;
            bus_wr    <= 1'b0;
            bus_size  <= 2'd0;
            bus_addr  <= '0;
            bus_wstrb <= '0;
            bus_wdata <= '0;
            r_off     <= '0;
            r_signed  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            bus_req   <= (next_state == ADDR);
            rsp_valid <= (next_state == DONE);
            if (accept) begin
                bus_wr    <= req_we;
                bus_size  <= eff_size;
                bus_addr  <= acc_addr;
                bus_wstrb <= req_we ? strb : '0;
                bus_wdata <= req_we ? wdata_steer : '0;
                r_off     <= off;
                r_signed  <= req_signed;
            end
            if (state == DATA && next_state == DONE)
                rsp_rdata <= bus_wr ? '0 : load_ext;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed bench for mem_access_unit (32-bit and 64-bit instances)
module tb_mem_access_unit;
    logic        clk;
    logic        rst;
    int          n_tests;
    int          n_fail;

    logic        req_valid, req_we, req_signed, flush, addr_ok, data_ok;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata, rdata;
    logic        busy, rsp_valid, adel, ades, bus_req, bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] rsp_rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;

    logic        w_req_valid, w_req_we, w_req_signed, w_flush, w_addr_ok, w_data_ok;
    logic [1:0]  w_req_size;
    logic [31:0] w_req_addr, w_bus_addr;
    logic [63:0] w_req_wdata, w_rdata, w_rsp_rdata, w_bus_wdata;
    logic        w_busy, w_rsp_valid, w_adel, w_ades, w_bus_req, w_bus_wr;
    logic [1:0]  w_bus_size;
    logic [7:0]  w_bus_wstrb;

    logic        o_busy_acc, o_req, o_wr, o_rsp, o_busy_done, o_rsp_after;
    logic [31:0] o_addr;
    logic [63:0] o_wdata, o_rdata;
    logic [7:0]  o_wstrb;

    mem_access_unit #(.DATA_W(32), .ADDR_W(32)) u32 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush),
        .busy(busy), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .adel(adel), .ades(ades),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_addr_ok(addr_ok),
        .bus_data_ok(data_ok), .bus_rdata(rdata)
    );

    mem_access_unit #(.DATA_W(64), .ADDR_W(32)) u64 (
        .clk(clk), .rst(rst), .req_valid(w_req_valid), .req_we(w_req_we), .req_size(w_req_size),
        .req_signed(w_req_signed), .req_addr(w_req_addr), .req_wdata(w_req_wdata), .flush(w_flush),
        .busy(w_busy), .rsp_valid(w_rsp_valid), .rsp_rdata(w_rsp_rdata), .adel(w_adel), .ades(w_ades),
        .bus_req(w_bus_req), .bus_wr(w_bus_wr), .bus_size(w_bus_size), .bus_addr(w_bus_addr),
        .bus_wstrb(w_bus_wstrb), .bus_wdata(w_bus_wdata), .bus_addr_ok(w_addr_ok),
        .bus_data_ok(w_data_ok), .bus_rdata(w_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction on the 32-bit unit; addr_ok waits dly extra cycles, data_ok follows addr_ok.
    task automatic txn(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rd, input int dly);
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wd;
        #1 o_busy_acc = busy;
        tick();
        req_valid = 1'b0;
        o_req = bus_req; o_wr = bus_wr; o_addr = bus_addr;
        o_wstrb = 8'(bus_wstrb); o_wdata = 64'(bus_wdata);
        repeat (dly) tick();
        addr_ok = 1'b1;
        tick();
        addr_ok = 1'b0; data_ok = 1'b1; rdata = rd;
        tick();
        data_ok = 1'b0;
        o_rsp = rsp_valid; o_rdata = 64'(rsp_rdata); o_busy_done = busy;
        tick();
        o_rsp_after = rsp_valid;
    endtask

    task automatic txn64(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [63:0] wd, input logic [63:0] rd);
        w_req_valid = 1'b1; w_req_we = we; w_req_size = size; w_req_signed = sgn;
        w_req_addr = addr; w_req_wdata = wd;
        tick();
        w_req_valid = 1'b0;
        o_req = w_bus_req; o_addr = w_bus_addr; o_wstrb = w_bus_wstrb; o_wdata = w_bus_wdata;
        w_addr_ok = 1'b1;
        tick();
        w_addr_ok = 1'b0; w_data_ok = 1'b1; w_rdata = rd;
        tick();
        w_data_ok = 1'b0;
        o_rsp = w_rsp_valid; o_rdata = w_rsp_rdata;
        tick();
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        rst = 1'b0;
        req_valid = 0; req_we = 0; req_size = 0; req_signed = 0; req_addr = 0; req_wdata = 0;
        flush = 0; addr_ok = 0; data_ok = 0; rdata = 0;
        w_req_valid = 0; w_req_we = 0; w_req_size = 0; w_req_signed = 0; w_req_addr = 0;
        w_req_wdata = 0; w_flush = 0; w_addr_ok = 0; w_data_ok = 0; w_rdata = 0;
        tick(); tick();
        chk("rst_bus_req", bus_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_wstrb", bus_wstrb, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_w_bus_req", w_bus_req, 0);
        rst = 1'b1;
        tick();

        // SB at 0x1003
        txn(1'b1, 2'd0, 1'b0, 32'h1003, 32'h0000_00AB, 32'h0, 0);
        chk("sb_busy_acc", o_busy_acc, 1);
        chk("sb_bus_req", o_req, 1);
        chk("sb_bus_wr", o_wr, 1);
        chk("sb_addr", o_addr, 32'h1003);
        chk("sb_wstrb", o_wstrb, 8'h08);
        chk("sb_wdata", o_wdata, 64'hAB00_0000);
        chk("sb_rsp", o_rsp, 1);
        chk("sb_rsp_rdata", o_rdata, 0);
        chk("sb_busy_done", o_busy_done, 0);
        chk("sb_rsp_once", o_rsp_after, 0);

        // LH / LHU at 0x2002
        txn(1'b0, 2'd1, 1'b1, 32'h2002, 32'h0, 32'h8001_1234, 0);
        chk("lh_wstrb", o_wstrb, 0);
        chk("lh_wr", o_wr, 0);
        chk("lh_rsp", o_rsp, 1);
        chk("lh_rdata", o_rdata, 64'hFFFF_8001);
        txn(1'b0, 2'd1, 1'b0, 32'h2002, 32'h0, 32'h8001_1234, 0);
        chk("lhu_rdata", o_rdata, 64'h0000_8001);

        // byte loads and other stores
        txn(1'b0, 2'd0, 1'b1, 32'h4001, 32'h0, 32'h0000_8000, 0);
        chk("lb_rdata", o_rdata, 64'hFFFF_FF80);
        txn(1'b0, 2'd0, 1'b0, 32'h4003, 32'h0, 32'h7F00_0000, 1);
        chk("lbu_rdata", o_rdata, 64'h0000_007F);
        txn(1'b1, 2'd1, 1'b0, 32'h5002, 32'h0000_1234, 32'h0, 0);
        chk("sh_wstrb", o_wstrb, 8'h0C);
        chk("sh_wdata", o_wdata, 64'h1234_0000);
        txn(1'b1, 2'd2, 1'b0, 32'h6000, 32'hCAFE_F00D, 32'h0, 0);
        chk("sw_wstrb", o_wstrb, 8'h0F);
        chk("sw_wdata", o_wdata, 64'hCAFE_F00D);

        // misaligned LW at 0x3002
`ifdef MEM_UNALIGNED_EXC_EN
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h3002;
        #1;
        chk("lw_mis_adel", adel, 1);
        chk("lw_mis_ades", ades, 0);
        chk("lw_mis_busy", busy, 0);
        tick();
        chk("lw_mis_no_req", bus_req, 0);
        req_valid = 1'b0;
        tick();
`else
        txn(1'b0, 2'd2, 1'b0, 32'h3002, 32'h0, 32'hDEAD_BEEF, 0);
        chk("lw_mis_addr", o_addr, 32'h3000);
        chk("lw_mis_rdata", o_rdata, 64'hDEAD_BEEF);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h3002;
        #1 chk("lw_mis_no_adel", adel, 0);
        req_valid = 1'b0;
        tick();
`endif

        // delayed addr_ok with flush in ADDR and in DATA
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h7000;
        tick();
        req_valid = 1'b0;
        chk("fl_req_t1", bus_req, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_req_hold1", bus_req, 1);
        tick();
        chk("fl_req_hold2", bus_req, 1);
        addr_ok = 1'b1;
        tick();
        addr_ok = 1'b0;
        chk("fl_req_drop", bus_req, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_busy_data", busy, 1);
        data_ok = 1'b1; rdata = 32'h1111_1111;
        tick();
        data_ok = 1'b0;
        chk("fl_no_rsp", rsp_valid, 0);
        chk("fl_busy_idle", busy, 0);
        tick();
        chk("fl_no_rsp2", rsp_valid, 0);

        // reset while in DATA, stray data_ok afterwards
        req_valid = 1'b1; req_addr = 32'h7100;
        tick();
        req_valid = 1'b0; addr_ok = 1'b1;
        tick();
        addr_ok = 1'b0;
        rst = 1'b0;
        #1;
        chk("rmid_bus_req", bus_req, 0);
        chk("rmid_busy", busy, 0);
        chk("rmid_addr", bus_addr, 0);
        tick();
        rst = 1'b1;
        data_ok = 1'b1;
        tick();
        data_ok = 1'b0;
        chk("rmid_no_rsp", rsp_valid, 0);
        chk("rmid_busy_idle", busy, 0);
        txn(1'b1, 2'd2, 1'b0, 32'h7200, 32'h5555_AAAA, 32'h0, 0);
        chk("rmid_next_req", o_req, 1);
        chk("rmid_next_rsp", o_rsp, 1);

        // 64-bit unit: SD at offset 0, LW signed at offset 4
        txn64(1'b1, 2'd3, 1'b0, 32'h8000, 64'h1122_3344_5566_7788, 64'h0);
        chk("sd_req", o_req, 1);
        chk("sd_wstrb", o_wstrb, 8'hFF);
        chk("sd_wdata", o_wdata, 64'h1122_3344_5566_7788);
        chk("sd_rsp", o_rsp, 1);
        txn64(1'b0, 2'd2, 1'b1, 32'h8004, 64'h0, 64'hF000_0000_0000_0000);
        chk("lw64_wstrb", o_wstrb, 8'h00);
        chk("lw64_rdata", o_rdata, 64'hFFFF_FFFF_F000_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised memory-stage load/store unit for the MIPS pipeline. It replaces fixed 32-bit store strobe and data steering with a unit that handles both loads and stores for a configurable data width. It drives an SRAM-like req/addr_ok/data_ok bus to the cache/bridge and stalls the pipeline while a transaction is outstanding. It also aligns and extends load data and flags address errors.

## Interface
- DATA_W, 32, data bus width in bits; legal values 32 or 64
- ADDR_W, 32, address width
- OFF_W, log2(DATA_W/8), derived byte-offset width; not overridable
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  memory instruction present in M stage
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 byte, 1 half, 2 word, 3 dword (legal only when DATA_W=64)
- req_signed  in  1  sign-extend load result
- req_addr  in  ADDR_W  effective address
- req_wdata  in  DATA_W  store data, right-justified
- flush  in  1  discard the in-flight instruction (exception/eret)
- busy  out  1  stall request to the pipeline
- rsp_valid  out  1  one-cycle load/store completion pulse
- rsp_rdata  out  DATA_W  aligned, extended load data; 0 for stores
- adel / ades  out  1 each  load / store address error
- bus_req, bus_wr  out  1  request valid, write
- bus_size  out  2  equals req_size
- bus_addr  out  ADDR_W  request address
- bus_wstrb  out  DATA_W/8  byte strobes; all-zero for loads
- bus_wdata  out  DATA_W  lane-steered store data
- bus_addr_ok, bus_data_ok  in  1  address accepted, data returned
- bus_rdata  in  DATA_W  raw read data

## Operation
- The FSM has four states: IDLE, ADDR, DATA, DONE.
- **IDLE:**
  - On req_valid with no address error, capture the op, address, strobes and steered wdata into registers, then go to ADDR.
  - On req_valid with an address error, do not issue a bus request and stay in IDLE.
- **ADDR:** bus_req=1 with the registered fields. When bus_addr_ok=1, go to DATA. bus_req must not drop before addr_ok, even if flush is asserted.
- **DATA:** Wait for bus_data_ok. When it arrives, latch the aligned result and go to DONE, or go to IDLE if the discard flag is set.
- **DONE:**
  - rsp_valid=1 and busy=0 for exactly one cycle.
  - No new request is accepted in this state.
  - Go to IDLE.
- **Discard flag:**
  - Set by flush in ADDR or DATA; cleared on entry to IDLE.
  - Flush in IDLE or DONE has no effect.
- **busy:** busy = (state∈{ADDR,DATA}) | (state==IDLE & req_valid & ~err).
- **Strobes and write data:**
  - off = addr[OFF_W-1:0].
  - bus_wstrb = ((1<<(1<<size))-1) << off.
  - bus_wdata = req_wdata << 8·off.
- **Load data:** rsp_rdata = extend(bus_rdata >> 8·off, size, req_signed). Zero-extend when req_signed=0; word loads with DATA_W=32 are unchanged.
- **Address errors:**
  - err = misalignment: half needs addr[0]=0, word needs addr[1:0]=0, dword needs addr[2:0]=0.
  - req_size=3 with DATA_W=32 is treated as an error.
  - adel = err & ~req_we; ades = err & req_we. Both are combinational and valid only in IDLE.
- **Ignored inputs:** bus_addr_ok and bus_data_ok are ignored in IDLE and DONE.

## Timing
- **Reset:** state=IDLE, discard=0; every output is 0, including bus_req, busy and rsp_valid. Reset mid-transaction abandons the transaction, and a later data_ok is ignored.
- **Issue:** accept at cycle T; bus_req is first high at T+1. addr_ok may arrive at T+1 or later.
- **data_ok:** arrives no earlier than the cycle after addr_ok.
- **Minimum latency:** accept T → rsp_valid at T+3, when addr_ok arrives at T+1 and data_ok at T+2.
- **Throughput:** busy falls in the DONE cycle; the next request is accepted at DONE+1 at the earliest.
- **Register timing:** all bus_* outputs and rsp_* outputs are registered. busy, adel and ades are combinational.

## Configuration
- MEM_UNALIGNED_EXC_EN defined:
  - misalignment raises adel/ades as above.
- Not defined:
  - bus_addr low bits are forced to zero for the access size;
  - err is forced to 0 (adel = ades = 0);
  - an illegal dword on DATA_W=32 is treated as word.

## Test plan
- SB, DATA_W=32, addr 0x1003, wdata 0x000000AB → bus_wstrb=4'b1000, bus_wdata=0xAB000000, bus_wr=1, rsp_valid pulses once.
- LH signed, addr 0x2002, bus_rdata 0x8001_1234 → rsp_rdata 0xFFFF8001. Same with LHU → 0x00008001.
- LW at 0x3002 with the macro on → adel=1, bus_req stays 0, busy=0. Macro off → bus_addr 0x3000, normal load.
- addr_ok delayed 3 cycles, then flush while in DATA → bus_req held until addr_ok, no rsp_valid, IDLE after data_ok, busy low the same cycle.
- DATA_W=64, SD at offset 0 and LW signed at offset 4 with bus_rdata 0xF0000000_00000000 → wstrb 8'hFF; rsp_rdata 0xFFFFFFFF_F0000000.
- rst low while in DATA, then data_ok pulse after release → no rsp_valid, all outputs 0, next request issues normally.
